// File: rtl/fft_stage2_sdf_pkg.sv
// rtl/fft_stage2_sdf_pkg.sv - shared constants and state encoding for the final radix-2 SDF stage
package fft_stage2_sdf_pkg;

    localparam int FFT_FRAME_LEN = 32;
    localparam int STAGE2_IN_W   = 15;
    localparam int STAGE2_OUT_W  = 16;

    typedef logic [1:0] sdf_state_t;

    localparam sdf_state_t ST_IDLE = 2'd0;
    localparam sdf_state_t ST_HOLD = 2'd1;
    localparam sdf_state_t ST_EMIT = 2'd2;

    // Frame-position counter step with wrap at the last index of the frame.
    function automatic logic [4:0] idx_inc(input logic [4:0] v, input logic [4:0] last);
        return (v == last) ? 5'd0 : v + 5'd1;
    endfunction

endpackage

// File: rtl/fft_stage2_sdf_bfly2.sv
// rtl/fft_stage2_sdf_bfly2.sv - combinational sign-extending radix-2 butterfly (twiddle = 1)
module bfly2
    import fft_stage2_sdf_pkg::*;
#(
    parameter int IN_W  = STAGE2_IN_W,
    parameter int OUT_W = STAGE2_OUT_W
) (
    input  logic signed [IN_W-1:0]  a_r,
    input  logic signed [IN_W-1:0]  a_i,
    input  logic signed [IN_W-1:0]  b_r,
    input  logic signed [IN_W-1:0]  b_i,
    output logic signed [OUT_W-1:0] sum_r,
    output logic signed [OUT_W-1:0] sum_i,
    output logic signed [OUT_W-1:0] diff_r,
    output logic signed [OUT_W-1:0] diff_i
);

    // One guard bit is enough: operands are extended before the add so nothing can wrap.
    always_comb begin
        sum_r  = OUT_W'(a_r) + OUT_W'(b_r);
        sum_i  = OUT_W'(a_i) + OUT_W'(b_i);
        diff_r = OUT_W'(a_r) - OUT_W'(b_r);
        diff_i = OUT_W'(a_i) - OUT_W'(b_i);
    end

endmodule

// File: rtl/fft_stage2_sdf.sv
// rtl/fft_stage2_sdf.sv - final radix-2 single-path-delay-feedback stage of the 32-point DIF FFT
module fft_stage2_sdf
    import fft_stage2_sdf_pkg::*;
#(
    parameter int FRAME_LEN = FFT_FRAME_LEN,
    parameter int IN_W      = STAGE2_IN_W,
    parameter int OUT_W     = STAGE2_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_i,
    input  logic signed [IN_W-1:0]  data_in_r,
    input  logic signed [IN_W-1:0]  data_in_i,
    output logic                    valid_o,
    output logic signed [OUT_W-1:0] data_out_r,
    output logic signed [OUT_W-1:0] data_out_i,
    output logic [4:0]              out_idx,
    output logic                    last_o
);

    localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);

    sdf_state_t              state;
    logic signed [OUT_W-1:0] hold_r;
    logic signed [OUT_W-1:0] hold_i;
    logic [4:0]              in_cnt;
    logic [4:0]              next_idx;

    logic signed [OUT_W-1:0] sum_r;
    logic signed [OUT_W-1:0] sum_i;
    logic signed [OUT_W-1:0] diff_r;
    logic signed [OUT_W-1:0] diff_i;

    // In HOLD the register only ever contains a sign-extended input, so its low IN_W bits are the sample.
    bfly2 #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_bfly2 (
        .a_r    (hold_r[IN_W-1:0]),
        .a_i    (hold_i[IN_W-1:0]),
        .b_r    (data_in_r),
        .b_i    (data_in_i),
        .sum_r  (sum_r),
        .sum_i  (sum_i),
        .diff_r (diff_r),
        .diff_i (diff_i)
    );

    // Index of the next output: continue the running count if an output is already on the bus, else start at 0.
    always_comb begin
        next_idx = valid_o ? idx_inc(out_idx, LAST_IDX) : 5'd0;
    end

    // Pairing FSM: store the even sample, emit sum with the odd one, then emit the stored difference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hold_r     <= '0;
            hold_i     <= '0;
            in_cnt     <= '0;
            valid_o    <= 1'b0;
            data_out_r <= '0;
            data_out_i <= '0;
            out_idx    <= '0;
            last_o     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    valid_o <= 1'b0;
                    last_o  <= 1'b0;
                    out_idx <= '0;
                    if (valid_i) begin
                        hold_r <= OUT_W'(data_in_r);
                        hold_i <= OUT_W'(data_in_i);
                        in_cnt <= 5'd1;
                        state  <= ST_HOLD;
                    end else begin
                        in_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (valid_i) begin
                        data_out_r <= sum_r;
                        data_out_i <= sum_i;
                        hold_r     <= diff_r;
                        hold_i     <= diff_i;
                        valid_o    <= 1'b1;
                        out_idx    <= next_idx;
                        last_o     <= (next_idx == LAST_IDX);
                        in_cnt     <= idx_inc(in_cnt, LAST_IDX);
                        state      <= ST_EMIT;
                    end else begin
                        // Gap inside a pair: the lone even sample has no partner and is dropped.
                        hold_r  <= '0;
                        hold_i  <= '0;
                        valid_o <= 1'b0;
                        last_o  <= 1'b0;
                        out_idx <= '0;
                        in_cnt  <= '0;
                        state   <= ST_IDLE;
                    end
                end
                ST_EMIT: begin
                    data_out_r <= hold_r;
                    data_out_i <= hold_i;
                    valid_o    <= 1'b1;
                    out_idx    <= next_idx;
                    last_o     <= (next_idx == LAST_IDX);
                    if (valid_i) begin
                        // Same edge drains the difference and captures the next even sample.
                        hold_r <= OUT_W'(data_in_r);
                        hold_i <= OUT_W'(data_in_i);
                        in_cnt <= idx_inc(in_cnt, LAST_IDX);
                        state  <= ST_HOLD;
                    end else begin
                        in_cnt <= '0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    last_o  <= 1'b0;
                    out_idx <= '0;
                    in_cnt  <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_stage2_sdf.sv
// tb/tb_fft_stage2_sdf.sv - scoreboard bench for fft_stage2_sdf
module tb_fft_stage2_sdf;

    localparam int IN_W  = 15;
    localparam int OUT_W = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    valid_i;
    logic signed [IN_W-1:0]  data_in_r;
    logic signed [IN_W-1:0]  data_in_i;
    logic                    valid_o;
    logic signed [OUT_W-1:0] data_out_r;
    logic signed [OUT_W-1:0] data_out_i;
    logic [4:0]              out_idx;
    logic                    last_o;

    typedef struct {
        int r;
        int i;
        int idx;
        bit last;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    fft_stage2_sdf #(
        .FRAME_LEN (32),
        .IN_W      (IN_W),
        .OUT_W     (OUT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .data_in_r  (data_in_r),
        .data_in_i  (data_in_i),
        .valid_o    (valid_o),
        .data_out_r (data_out_r),
        .data_out_i (data_out_i),
        .out_idx    (out_idx),
        .last_o     (last_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, queue=%0d", q.size());
        $fatal(1, "watchdog expired");
    end

    // Monitor: pops one expectation per valid output and checks value, index, flag and arrival cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (valid_o === 1'b1) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out cyc=%0d: got r=%0d i=%0d idx=%0d last=%0d, want no output",
                             cyc, int'(data_out_r), int'(data_out_i), out_idx, last_o);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (int'(data_out_r) != e.r || int'(data_out_i) != e.i || int'(out_idx) != e.idx ||
                        last_o !== e.last || cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL out_%0d: got r=%0d i=%0d idx=%0d last=%0d cyc=%0d, want r=%0d i=%0d idx=%0d last=%0d cyc=%0d",
                                 e.idx, int'(data_out_r), int'(data_out_i), out_idx, last_o, cyc,
                                 e.r, e.i, e.idx, e.last, e.cyc);
                    end
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                e = q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL missing_out_%0d: got valid_o=%0b at cyc=%0d, want r=%0d i=%0d at cyc=%0d",
                         e.idx, valid_o, cyc, e.r, e.i, e.cyc);
            end
        end
    end

    task automatic chk(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid_o"}, int'(valid_o), 0);
        chk({tag, "_data_out_r"}, int'(data_out_r), 0);
        chk({tag, "_data_out_i"}, int'(data_out_i), 0);
        chk({tag, "_out_idx"}, int'(out_idx), 0);
        chk({tag, "_last_o"}, int'(last_o), 0);
    endtask

    task automatic push(input int r, input int i, input int idx, input int c);
        exp_t e;
        e.r    = r;
        e.i    = i;
        e.idx  = idx;
        e.last = (idx == 31);
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic drive(input int r, input int i, output int c);
        @(negedge clk);
        valid_i   = 1'b1;
        data_in_r = IN_W'(r);
        data_in_i = IN_W'(i);
        c         = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_i   = 1'b0;
            data_in_r = '0;
            data_in_i = '0;
        end
    endtask

    // Ramp x[n] = (n, -n): pair m gives sum (4m+1, -(4m+1)) and difference (-1, +1).
    task automatic ramp(input int nsamp, input int max_out);
        int c0;
        int c;
        int m;
        c0 = 0;
        for (int n = 0; n < nsamp; n++) begin
            drive(n, -n, c);
            if (n == 0) c0 = c;
            if (n % 2 == 1) begin
                m = n / 2;
                if (2 * m < max_out)     push(4 * m + 1, -(4 * m + 1), 2 * m, c0 + 2 * m + 2);
                if (2 * m + 1 < max_out) push(-1, 1, 2 * m + 1, c0 + 2 * m + 3);
            end
        end
    endtask

    // Full-scale operands: shows the extra output bit absorbs every sum and difference.
    task automatic extremes();
        int c0;
        int c;
        drive(16383, -16384, c0);
        drive(16383, -16384, c);
        push(32766, -32768, 0, c0 + 2);
        push(0, 0, 1, c0 + 3);
        drive(16383, -16384, c);
        drive(-16384, 16383, c);
        push(-1, -1, 2, c0 + 4);
        push(32767, -32767, 3, c0 + 5);
        for (int m = 2; m < 16; m++) begin
            drive(0, 0, c);
            drive(0, 0, c);
            push(0, 0, 2 * m, c0 + 2 * m + 2);
            push(0, 0, 2 * m + 1, c0 + 2 * m + 3);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        valid_i   = 1'b0;
        data_in_r = '0;
        data_in_i = '0;
        #7;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        ramp(32, 32);
        idle(4);

        extremes();
        idle(3);

        ramp(32, 32);
        ramp(32, 32);
        idle(3);

        ramp(5, 32);
        idle(2);
        ramp(32, 32);
        idle(3);

        ramp(11, 9);
        #2;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        idle(2);
        rst_n = 1'b1;
        ramp(32, 32);
        idle(5);

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL never_seen_%0d: got no output, want r=%0d i=%0d at cyc=%0d", e.idx, e.r, e.i, e.cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_stage2_sdf.md
# fft_stage2_sdf

Final radix-2 single-path-delay-feedback (SDF) stage of the 32-point DIF FFT pipeline. It sits directly downstream of the 4-point stage: it consumes that stage's butterfly output stream and applies the last 2-point butterfly. The twiddle is always W2^0 = 1, so there is no multiplier. It emits the 32 frequency bins in bit-reversed order, each with an index and a last-of-frame flag, for the reorder buffer.

## Interface
Parameters:
- `FRAME_LEN`, 32: samples per frame. Must be a power of two, at least 2.
- `IN_W`, 15: input component width (signed).
- `OUT_W`, 16: output component width. Must equal `IN_W`+1.

Ports (name, direction, width, meaning):
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `valid_i`  input  1  `data_in_*` carries a sample this cycle.
- `data_in_r`  input  `IN_W`  real part, signed.
- `data_in_i`  input  `IN_W`  imaginary part, signed.
- `valid_o`  output  1  `data_out_*` and `out_idx` are valid.
- `data_out_r`  output  `OUT_W`  real part, signed, registered.
- `data_out_i`  output  `OUT_W`  imaginary part, signed, registered.
- `out_idx`  output  5  position of the current output within the frame, 0..31 (bit-reversed bin number).
- `last_o`  output  1  high together with `valid_o` when `out_idx` == 31.

## Operation
- A frame is 32 samples on 32 consecutive `valid_i`-high cycles. Back-to-back frames need no gap. Samples pair up as (x[2m], x[2m+1]).
- One complex hold register, `OUT_W` wide, implements the delay-1 feedback. The FSM has states IDLE, HOLD and EMIT.
- IDLE:
  - `valid_o` <= 0.
  - If `valid_i`: hold <= sign-extended x, `in_cnt` <= 1, go to HOLD.
- HOLD (even sample stored):
  - If `valid_i`: `data_out` <= hold + x, hold <= hold − x (x sign-extended), `valid_o` <= 1, `in_cnt`++, go to EMIT.
  - Else (gap mid-pair): abort. The held sample is discarded, `valid_o` <= 0, counters clear, go to IDLE.
- EMIT (difference pending):
  - `data_out` <= hold, `valid_o` <= 1.
  - If `valid_i`: hold <= x, `in_cnt`++ (wraps 31 -> 0), go to HOLD. This covers both the next pair and the first sample of a new frame.
  - Else: go to IDLE. If `in_cnt` != 0 the frame was truncated; its already-produced outputs stand and the counters clear.
- Arithmetic:
  - Full precision. Inputs are sign-extended to `OUT_W` before add/subtract.
  - No rounding, no saturation, no overflow possible.
- Output index:
  - `out_idx` increments by 1 on every `valid_o`-high cycle and wraps 31 -> 0.
  - `out_idx` clears whenever the FSM enters IDLE.
  - `last_o` = `valid_o` && `out_idx` == 31. It is registered and aligned with the data.
- Real and imaginary paths are identical and independent.

## Timing
- Reset (asynchronous, `rst_n` low): state = IDLE, hold = 0, `in_cnt` = 0, and every output = 0. This applies mid-frame too: the partial frame is lost.
- Latency: x0 is presented in cycle 0. The sum x0+x1 appears in cycle 2 and the difference x0−x1 in cycle 3. Pair m yields its sum in cycle 2m+2 and its difference in cycle 2m+3.
- A frame presented in cycles 0..31 produces `valid_o` high in cycles 2..33, with `last_o` in cycle 33.
- Back-to-back frames: `valid_o` stays continuously high and `out_idx` runs 31 -> 0 seamlessly. In the same edge, EMIT outputs the old hold value and loads the new sample.
- There is no backpressure. The downstream block must accept one sample per cycle whenever `valid_o` is high.

## Structure
- Shared FFT package holds:
  - the state encoding (IDLE/HOLD/EMIT), as 2-bit localparams;
  - `FRAME_LEN`;
  - the stage data widths (15 in, 16 out).
- One sub-module is natural: `bfly2`, a combinational sign-extending add/sub of two complex operands. It is reused by the earlier radix-2 stages.
- `in_cnt` and `out_idx` are 5-bit counters in the top module.

## Test plan
- Single frame, x[n] = (n, −n) for n = 0..31:
  - output pair m is sum (4m+1, −(4m+1)) then difference (−1, +1);
  - `valid_o` is high in cycles 2..33;
  - `last_o` is high only in cycle 33.
- Extremes: x0 = (16383, −16384), x1 = (16383, −16384):
  - sum (32766, −32768), difference (0, 0);
  - x1 = (−16384, 16383) instead gives difference (32767, −32767), with no wrap.
- Two back-to-back frames: `valid_o` stays continuously high for 64 cycles; `out_idx` runs 0..31 then 0..31; `last_o` fires exactly twice.
- `valid_i` drops after 5 samples (mid-pair):
  - two sums and two differences are emitted;
  - the fifth sample is discarded;
  - `valid_o` is low from the next cycle;
  - the next frame restarts at `out_idx` 0.
- `rst_n` is asserted asynchronously in cycle 10 of a frame:
  - all outputs go to 0 immediately, without waiting for a clock edge;
  - a new frame after release produces correct results from `out_idx` 0.
